// File: rtl/ntt_twiddle_sequencer.sv
// Twiddle-ROM sequencer for an in-place Cooley-Tukey forward NTT.
// Issues one ROM read per butterfly and streams {twiddle, indices} through a 2-entry buffer.
module ntt_twiddle_sequencer #(
  parameter int N          = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int LOG2N      = $clog2(N),
  parameter int STAGE_W    = $clog2(LOG2N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stage_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_read_en,
  output logic [ADDR_WIDTH-1:0] rom_read_addr,
  input  logic [DATA_WIDTH-1:0] rom_read_data,
  output logic                  bf_valid,
  input  logic                  bf_ready,
  output logic [DATA_WIDTH-1:0] bf_twiddle,
  output logic [ADDR_WIDTH-1:0] bf_idx_a,
  output logic [ADDR_WIDTH-1:0] bf_idx_b,
  output logic [STAGE_W-1:0]    bf_stage,
  output logic                  bf_last
);

  // Stream contract: a descriptor transfers on a cycle with bf_valid & bf_ready;
  // while bf_valid is high without bf_ready, every bf_* output holds its value.

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx_a;
    logic [ADDR_WIDTH-1:0] idx_b;
    logic [STAGE_W-1:0]    stage;
    logic                  last;
  } meta_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] twiddle;
    meta_t                 meta;
  } desc_t;

  localparam logic [STAGE_W-1:0]    LAST_STAGE = STAGE_W'(LOG2N - 1);
  localparam logic [STAGE_W-1:0]    STAGE_ONE  = STAGE_W'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_BF    = ADDR_WIDTH'(N / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  meta_t                 meta_q, meta_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  desc_t                 slot0_q, slot0_d;
  desc_t                 slot1_q, slot1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Butterfly counter -> (group, offset): len = 2^shamt, offset = low shamt bits.
  logic [STAGE_W-1:0]    shamt;
  logic [ADDR_WIDTH-1:0] len, grp, off, k_addr, idx_a;
  logic                  is_last;

  always_comb begin
    shamt   = LAST_STAGE - stage_q;
    len     = ONE_A << shamt;
    grp     = cnt_q >> shamt;
    off     = cnt_q & (len - ONE_A);
    idx_a   = ((grp << shamt) << 1) | off;
    k_addr  = (ONE_A << stage_q) | grp;
    is_last = (cnt_q == LAST_BF);
  end

  desc_t      rom_desc, head;
  logic       valid_c, pop, issue;
  logic [2:0] held;

  // The returning ROM word is presented directly when the buffer is empty.
  always_comb begin
    rom_desc = '{twiddle: rom_read_data, meta: meta_q};
    head     = (occ_q == 2'd0 && inflight_q) ? rom_desc : slot0_q;
    valid_c  = (occ_q != 2'd0) || inflight_q;
    pop      = valid_c && bf_ready;
    held     = {1'b0, occ_q} + {2'b0, inflight_q};
    issue    = (state_q == S_ISSUE) && (held < (3'd2 + {2'b0, pop}));
  end

  assign rom_read_en   = issue;
  assign rom_read_addr = issue ? k_addr : addr_q;
  assign bf_valid      = valid_c;
  assign bf_twiddle    = head.twiddle;
  assign bf_idx_a      = head.meta.idx_a;
  assign bf_idx_b      = head.meta.idx_b;
  assign bf_stage      = head.meta.stage;
  assign bf_last       = head.meta.last;
  assign busy          = busy_q;
  assign done          = done_q;

  logic       shift_out, store_new;
  logic [1:0] occ_after;

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    meta_d     = meta_q;
    inflight_d = issue;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          if (is_last) begin
            cnt_d   = '0;
            state_d = (stage_q == LAST_STAGE) ? S_DRAIN : S_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + ONE_A;
          end
        end
      end
      S_WAIT_ACK: begin
        // The next stage reads coefficients this stage wrote, so fully drain first.
        if (stage_ack && occ_q == 2'd0 && !inflight_q) begin
          stage_d = stage_q + STAGE_ONE;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (occ_q == 2'd0 && !inflight_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      addr_d = k_addr;
      meta_d = '{idx_a: idx_a, idx_b: idx_a | len, stage: stage_q, last: is_last};
    end

    shift_out = pop && (occ_q != 2'd0);
    store_new = inflight_q && !(pop && occ_q == 2'd0);
    occ_after = occ_q - {1'b0, shift_out};
    slot0_d   = shift_out ? slot1_q : slot0_q;
    slot1_d   = slot1_q;
    if (store_new) begin
      if (occ_after == 2'd0) slot0_d = rom_desc;
      else                   slot1_d = rom_desc;
    end
    occ_d = occ_after + {1'b0, store_new};

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stage_q    <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      meta_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      meta_q     <= meta_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ntt_twiddle_sequencer.sv
// Directed bench for ntt_twiddle_sequencer at N=8 against a hand-computed descriptor table.
module tb_ntt_twiddle_sequencer;

  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int LOG2N = 3;
  localparam int SW    = 2;
  localparam int DESC_W = DW + AW + AW + SW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, start, stage_ack, bf_ready;
  logic busy, done, rom_read_en, bf_valid, bf_last;
  logic [AW-1:0] rom_read_addr, bf_idx_a, bf_idx_b;
  logic [DW-1:0] rom_read_data = '0;
  logic [DW-1:0] bf_twiddle;
  logic [SW-1:0] bf_stage;

  always #5 clk = ~clk;

  ntt_twiddle_sequencer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stage_ack(stage_ack),
    .busy(busy), .done(done),
    .rom_read_en(rom_read_en), .rom_read_addr(rom_read_addr), .rom_read_data(rom_read_data),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_twiddle(bf_twiddle),
    .bf_idx_a(bf_idx_a), .bf_idx_b(bf_idx_b), .bf_stage(bf_stage), .bf_last(bf_last)
  );

  // Twiddle ROM: word i = 0x100 + i, one cycle read latency.
  always @(posedge clk) if (rom_read_en) rom_read_data <= 32'h100 + 32'(rom_read_addr);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DESC_W-1:0] exp_q[$];

  int exp_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
  int exp_b [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
  int exp_t [12] = '{'h101, 'h101, 'h101, 'h101, 'h102, 'h102, 'h103, 'h103,
                     'h104, 'h105, 'h106, 'h107};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp_v, $time);
    end
  endtask

  function automatic logic [DESC_W-1:0] mk(input int a, input int b, input int tw,
                                           input int s, input int l);
    return {DW'(tw), AW'(a), AW'(b), SW'(s), 1'(l)};
  endfunction

  task automatic load_exp();
    exp_q.delete();
    for (int i = 0; i < 12; i++)
      exp_q.push_back(mk(exp_a[i], exp_b[i], exp_t[i], i / 4, (i % 4) == 3));
  endtask

  // ---------------- monitor ----------------
  logic [DESC_W-1:0] cur, prev_desc;
  assign cur = {bf_twiddle, bf_idx_a, bf_idx_b, bf_stage, bf_last};

  bit mon_en = 0;
  bit prev_stall = 0;
  int n_issue = 0, n_pop = 0, n_done = 0, lasts_popped = 0;

  always @(negedge clk) begin
    bit pop_now;
    if (!mon_en) begin
      prev_stall = 0;
      n_issue    = 0;
      n_pop      = 0;
    end else begin
      pop_now = bf_valid && bf_ready;
      if (rom_read_en) check("credit", ((n_issue - n_pop - int'(pop_now)) < 2), 1);
      if (prev_stall) begin
        check("hold_valid", bf_valid, 1);
        check("hold_desc", cur, prev_desc);
      end
      if (pop_now) begin
        if (exp_q.size() == 0) check("extra_pop", 1, 0);
        else check("desc", cur, exp_q.pop_front());
        if (bf_last) lasts_popped++;
      end
      if (done) begin
        n_done++;
        check("done_after_all", exp_q.size(), 0);
      end
      n_issue    += int'(rom_read_en);
      n_pop      += int'(pop_now);
      prev_stall = bf_valid && !bf_ready;
      prev_desc  = cur;
    end
  end

  // ---------------- driver tasks ----------------
  int ready_mode = 0;
  bit auto_ack   = 0;
  int acks_sent  = 0;
  int base_last  = 0;
  int base_done  = 0;
  int pat_i      = 0;

  // Advance to just after the next rising edge and apply automatic stimulus.
  task automatic step();
    @(posedge clk);
    #1;
    pat_i++;
    if (ready_mode == 1) bf_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
    if (auto_ack) begin
      stage_ack = 0;
      if (acks_sent < lasts_popped - base_last && lasts_popped - base_last < LOG2N) begin
        stage_ack = 1;
        acks_sent++;
      end
    end
  endtask

  task automatic begin_run(input int rmode, input bit aack);
    load_exp();
    acks_sent  = 0;
    base_last  = lasts_popped;
    base_done  = n_done;
    pat_i      = 0;
    ready_mode = rmode;
    auto_ack   = aack;
    bf_ready   = 1;
    stage_ack  = 0;
    mon_en     = 1;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else step();
    end
    check("done_in_time", seen, 1);
  endtask

  task automatic finish_run();
    wait_done(300);
    step();
    start = 0;
    step();
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_ren", rom_read_en, 0);
    check("done_once", n_done - base_done, 1);
    check("all_popped", exp_q.size(), 0);
    ready_mode = 0;
    auto_ack   = 0;
    stage_ack  = 0;
    step();
  endtask

  task automatic run_full(input int rmode, input bit hold_start);
    begin_run(rmode, 1);
    step(); start = 1;
    step(); if (!hold_start) start = 0;
    finish_run();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1; start = 0; stage_ack = 0; bf_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ren", rom_read_en, 0);
    check("rst_addr", rom_read_addr, 0);
    check("rst_valid", bf_valid, 0);
    check("rst_last", bf_last, 0);
    check("rst_idx_a", bf_idx_a, 0);
    check("rst_idx_b", bf_idx_b, 0);
    check("rst_stage", bf_stage, 0);
    check("rst_twiddle", bf_twiddle, 0);

    // stage_ack while idle does nothing
    step(); stage_ack = 1;
    step(); stage_ack = 0;
    @(negedge clk);
    check("idle_ack_busy", busy, 0);
    check("idle_ack_ren", rom_read_en, 0);

    // Latency / throughput with manual ack of stage 0
    begin_run(0, 0);
    step(); start = 1;
    step(); start = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("lat_ren", rom_read_en, (c >= 1 && c <= 4));
      check("lat_valid", bf_valid, (c >= 2 && c <= 5));
      check("lat_busy", busy, 1);
      if (c < 8) step();
    end
    step(); stage_ack = 1;
    @(negedge clk);
    check("lat_ack_ren", rom_read_en, 0);
    step(); stage_ack = 0; acks_sent = 1; auto_ack = 1;
    @(negedge clk);
    check("lat_resume_ren", rom_read_en, 1);
    step();
    finish_run();

    // Backpressure: bf_ready 1,0,0,1 repeating
    run_full(1, 0);

    // Stage gating: early ack in ISSUE, held ack while buffer is occupied
    begin_run(0, 0);
    step(); start = 1;
    step(); start = 0;
    step(); stage_ack = 1;
    step(); stage_ack = 0;
    step(); bf_ready = 0;
    step(); stage_ack = 1;
    for (int c = 5; c <= 12; c++) begin
      @(negedge clk);
      check("gate_no_issue", rom_read_en, 0);
      check("gate_valid", bf_valid, (c <= 11));
      step();
      if (c == 9) bf_ready = 1;
    end
    stage_ack = 0;
    @(negedge clk);
    check("gate_resume", rom_read_en, 1);
    acks_sent = 1; auto_ack = 1;
    step();
    finish_run();

    // Reset mid-transform, then a clean transform
    begin_run(1, 1);
    step(); start = 1;
    step(); start = 0;
    repeat (6) step();
    mon_en = 0; rst = 1;
    step(); rst = 0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", bf_valid, 0);
    check("abort_ren", rom_read_en, 0);
    check("abort_done", done, 0);
    exp_q.delete();
    ready_mode = 0; auto_ack = 0; stage_ack = 0;
    step();
    run_full(0, 0);

    // start held through the whole transform and its done cycle, then a fresh start
    run_full(0, 1);
    run_full(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
